// File: rtl/multi_channel_histogram.sv
// multi_channel_histogram: NUM_CH independent histograms sharing one bin-code
// stream. Updates go through a 2-stage read-modify-write pipeline with
// forwarding; the whole table can be cleared or streamed out over valid/ready.
// Optional feature: define HIST_SATURATE_EN to make bins saturate at the
// maximum count instead of wrapping to zero.
module multi_channel_histogram #(
  parameter int WIDTH  = 8,
  parameter int SIZED  = 6,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_update_enable,
  input  logic [NUM_CH*WIDTH-1:0] i_bin,
  input  logic                    i_clear,
  input  logic                    i_read_start,
  input  logic                    i_read_ready,
  output logic                    o_read_valid,
  output logic [NUM_CH*SIZED-1:0] o_read_data,
  output logic [WIDTH-1:0]        o_read_addr,
  output logic                    o_read_last,
  output logic                    o_busy
);

  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0]   DEPTH_W   = (WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);
  localparam logic [SIZED-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_CLEAR, ST_ACCUM, ST_DRAIN_R, ST_DRAIN_C, ST_READ
  } state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          addr_q, addr_d;      // clear / read address
  logic [NUM_CH-1:0]         s1_valid_q, s1_valid_d;
  logic [AW-1:0]             s1_addr_q [NUM_CH];
  logic [AW-1:0]             s1_addr_d [NUM_CH];
  logic [SIZED-1:0]          s1_rdata_q [NUM_CH];
  logic [SIZED-1:0]          s1_rdata_d [NUM_CH];
  logic [NUM_CH-1:0]         s2_valid_q, s2_valid_d;
  logic [AW-1:0]             s2_addr_q [NUM_CH];
  logic [AW-1:0]             s2_addr_d [NUM_CH];
  logic [SIZED-1:0]          s2_data_q [NUM_CH];
  logic [SIZED-1:0]          s2_data_d [NUM_CH];
  logic                      rd_valid_q, rd_valid_d;
  logic [NUM_CH*SIZED-1:0]   rd_data_q, rd_data_d;
  logic [WIDTH-1:0]          rd_addr_q, rd_addr_d;
  logic                      rd_last_q, rd_last_d;

  logic [SIZED-1:0]          mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0]         mem_we;
  logic [AW-1:0]             mem_waddr [NUM_CH];
  logic [SIZED-1:0]          mem_wdata [NUM_CH];
  logic                      accept;
  logic                      pipe_busy;

  function automatic logic [SIZED-1:0] bump(input logic [SIZED-1:0] v);
`ifdef HIST_SATURATE_EN
    return (v == CNT_MAX) ? v : v + SIZED'(1);
`else
    return v + SIZED'(1);
`endif
  endfunction

  assign accept    = (state_q == ST_ACCUM) && i_update_enable;
  assign pipe_busy = |s1_valid_q;

  // Update pipeline: stage 1 captures the bin read, stage 2 commits the
  // increment; a stage-2 hit on the same bin forwards the fresher count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      s1_valid_d[c] = accept && ({1'b0, i_bin[c*WIDTH +: WIDTH]} < DEPTH_W);
      s1_addr_d[c]  = i_bin[c*WIDTH +: AW];
      s1_rdata_d[c] = mem[c][i_bin[c*WIDTH +: AW]];
      s2_valid_d[c] = s1_valid_q[c];
      s2_addr_d[c]  = s1_addr_q[c];
      s2_data_d[c]  = (s2_valid_q[c] && (s2_addr_q[c] == s1_addr_q[c]))
                      ? bump(s2_data_q[c]) : bump(s1_rdata_q[c]);
    end
  end

  // Bin RAM write port: zero sweep while clearing, else the committed update.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mem_we[c]    = s1_valid_q[c];
      mem_waddr[c] = s1_addr_q[c];
      mem_wdata[c] = s2_data_d[c];
      if (state_q == ST_CLEAR) begin
        mem_we[c]    = 1'b1;
        mem_waddr[c] = addr_q[AW-1:0];
        mem_wdata[c] = '0;
      end
    end
  end

  // Bin RAM storage.
  // NOTE: the RAM has no reset; the CLEAR sweep after reset zeroes it.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (mem_we[c]) mem[c][mem_waddr[c]] <= mem_wdata[c];
    end
  end

  // Control FSM plus the registered read-out stage.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_last_d  = rd_last_q;
    case (state_q)
      ST_CLEAR: begin
        addr_d = addr_q + WIDTH'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = ST_ACCUM;
          addr_d  = '0;
        end
      end
      ST_ACCUM: begin
        if (i_clear)           state_d = ST_DRAIN_C;
        else if (i_read_start) state_d = ST_DRAIN_R;
      end
      ST_DRAIN_R: begin
        if (i_clear) begin
          state_d = ST_DRAIN_C;
        end else if (!pipe_busy) begin
          state_d    = ST_READ;
          addr_d     = '0;
          rd_valid_d = 1'b0;
        end
      end
      ST_DRAIN_C: begin
        if (!pipe_busy) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        if (i_clear) begin
          state_d    = ST_CLEAR;
          addr_d     = '0;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else if (rd_valid_q && i_read_ready && rd_last_q) begin
          state_d    = ST_ACCUM;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else if (!rd_valid_q || i_read_ready) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = addr_q;
          rd_last_d  = (addr_q == LAST_ADDR);
          for (int c = 0; c < NUM_CH; c++) begin
            rd_data_d[c*SIZED +: SIZED] = mem[c][addr_q[AW-1:0]];
          end
          addr_d = addr_q + WIDTH'(1);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_CLEAR;
      addr_q     <= '0;
      s1_valid_q <= '0;
      s2_valid_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        s1_addr_q[c]  <= '0;
        s1_rdata_q[c] <= '0;
        s2_addr_q[c]  <= '0;
        s2_data_q[c]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
      s1_addr_q  <= s1_addr_d;
      s1_rdata_q <= s1_rdata_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign o_read_valid = rd_valid_q;
  assign o_read_data  = rd_data_q;
  assign o_read_addr  = rd_addr_q;
  assign o_read_last  = rd_last_q;
  assign o_busy       = (state_q != ST_ACCUM);

endmodule

// File: doc/multi_channel_histogram.md
MULTI_CHANNEL_HISTOGRAM -- requirements
Module: multi_channel_histogram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, bin-code width per channel.
REQ-002 The block SHALL have parameter SIZED, default 6, bin-counter width.
REQ-003 The block SHALL have parameter DEPTH, default 256, bins per channel, with DEPTH <= 2**WIDTH.
REQ-004 The block SHALL have parameter NUM_CH, default 2, independent channels (ch0 = NI, ch1 = RD).
REQ-005 The block SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 The block SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port i_update_enable  in  1  one bin-code set presented this cycle.
REQ-008 The block SHALL have port i_bin  in  NUM_CH*WIDTH  bin codes; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 The block SHALL have port i_clear  in  1  request to zero all bins.
REQ-010 The block SHALL have port i_read_start  in  1  request to stream the histogram out.
REQ-011 The block SHALL have port i_read_ready  in  1  downstream accepts the read beat.
REQ-012 The block SHALL have port o_read_valid  out  1  read beat valid.
REQ-013 The block SHALL have port o_read_data  out  NUM_CH*SIZED  bin counts of all channels for o_read_addr, same packing as i_bin.
REQ-014 The block SHALL have port o_read_addr  out  WIDTH  bin index of the current beat.
REQ-015 The block SHALL have port o_read_last  out  1  asserted with the beat for bin DEPTH-1.
REQ-016 The block SHALL have port o_busy  out  1  high in every state except ACCUM.

Function
REQ-017 The block SHALL implement the FSM states CLEAR, ACCUM, DRAIN_R, DRAIN_C and READ.
REQ-018 CLEAR SHALL write zero to one address per cycle, 0..DEPTH-1, in all channels, then go to ACCUM (DEPTH cycles total).
REQ-019 In ACCUM, each i_update_enable SHALL increment, for every channel c, bin i_bin[c] by 1 through a 2-stage read-modify-write pipeline (stage1 RAM read, stage2 write); throughput is 1 update/cycle.
REQ-020 Back-to-back or one-apart updates hitting the same bin in a channel SHALL be forwarded, so that N updates to one bin yield count N with no lost increments.
REQ-021 A channel code >= DEPTH SHALL be dropped for that channel only; other channels SHALL still update.
REQ-022 In ACCUM, i_clear SHALL go to DRAIN_C and i_read_start SHALL go to DRAIN_R; when both are asserted, i_clear SHALL win.
REQ-023 An update presented in the same cycle as i_clear or i_read_start SHALL be accepted and counted.
REQ-024 DRAIN_x SHALL wait until the pipeline is empty (at most 2 cycles), then enter CLEAR or READ respectively.
REQ-025 i_update_enable SHALL be ignored outside ACCUM, and i_read_start SHALL be ignored outside ACCUM.
REQ-026 READ SHALL stream addresses 0..DEPTH-1 with a valid/ready handshake, and a beat SHALL transfer when o_read_valid && i_read_ready.
REQ-027 o_read_valid SHALL rise no later than 2 cycles after entering READ.
REQ-028 o_read_data, o_read_addr and o_read_last SHALL be registered and held stable while o_read_valid && !i_read_ready.
REQ-029 A ready-high stream SHALL sustain one beat per cycle.
REQ-030 After the o_read_last beat transfers, the block SHALL return to ACCUM with o_read_valid low the next cycle; bins SHALL NOT be cleared by reading.
REQ-031 i_clear during READ SHALL abort the stream, deassert o_read_valid next cycle, and enter CLEAR.
REQ-032 Counter overflow at 2**SIZED-1 SHALL follow REQ-037.

Reset
REQ-033 i_rst sampled high SHALL force state CLEAR at address 0, flush the pipeline, and set o_read_valid=0, o_read_last=0, o_read_addr=0, o_read_data=0 and o_busy=1.
REQ-034 Reset asserted mid-update or mid-read SHALL discard in-flight updates and beats, and the block SHALL re-clear all bins before accepting updates.
REQ-035 After i_rst deasserts, o_busy SHALL fall exactly DEPTH cycles later.

Configuration
REQ-036 The block SHALL recognise macro HIST_SATURATE_EN.
REQ-037 With HIST_SATURATE_EN defined, a bin at 2**SIZED-1 SHALL stay at that value on increment; without it, the bin SHALL wrap to 0.

Verification
REQ-038 Reset, then 256 idle cycles -> o_busy falls at cycle 256; a full read returns 256 beats of 0, with o_read_last only on addr 255.
REQ-039 10 consecutive updates with i_bin={ch1=8'd3,ch0=8'd3}, then read -> bin 3 = {6'd10,6'd10}, all other bins 0 (forwarding check).
REQ-040 70 updates to ch0 bin 5 -> ch0 bin 5 reads 63 with HIST_SATURATE_EN defined, 6 (70 mod 64) without it.
REQ-041 During a read, toggle i_read_ready every cycle -> 256 beats, none duplicated or skipped, data stable while stalled; then ACCUM resumes and an update to bin 7 counts.
REQ-042 With DEPTH=200, i_bin ch0=8'd250, ch1=8'd4 -> ch0 unchanged, ch1 bin 4 = 1; then i_clear and i_read_start in the same cycle together with an update -> CLEAR taken and all bins read 0 afterwards.
